// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the Hack PC / instruction-fetch sequencer:
// FSM state encodings and the bit positions of the jump field.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    // j1 j2 j3 = jump on out<0, out==0, out>0
    localparam int J1 = 2;
    localparam int J2 = 1;
    localparam int J3 = 0;

endpackage

// File: rtl/jump_cond.sv
// Hack jump-condition evaluation: combines the C-instruction jump bits with the
// ALU zr/ng flags to decide whether the A register becomes the next PC.
module jump_cond
    import pc_fetch_pkg::*;
(
    input  logic       is_c,
    input  logic [2:0] jmp,
    input  logic       zr,
    input  logic       ng,
    output logic       taken
);

    // out>0 is neither negative nor zero; A-instructions never jump.
    assign taken = is_c & ((jmp[J1] & ng) | (jmp[J2] & zr) | (jmp[J3] & ~ng & ~zr));

endmodule

// File: rtl/pc_fetch.sv
// Hack program counter plus instruction-fetch sequencer with a req/ack ROM port,
// so wait-state ROMs can be placed behind it.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_rst,
    output logic [WIDTH-1:0] rom_addr,
    output logic             rom_req,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             is_c,
    input  logic [2:0]       jmp,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] pc
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] next_pc;
    logic             load_instr;
    logic             taken;

    jump_cond u_jump_cond (
        .is_c  (is_c),
        .jmp   (jmp),
        .zr    (zr),
        .ng    (ng),
        .taken (taken)
    );

    // Next-PC select: sequential fetch wraps modulo 2^WIDTH, jumps take A.
    assign pc_inc  = pc + WIDTH'(1);
    assign next_pc = taken ? a_in : pc_inc;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        pc_d       = pc;
        load_instr = 1'b0;
        if (soft_rst) begin
            // Restart wins over stall and over any ack arriving in the same cycle.
            next_state = S_IDLE;
            pc_d       = RESET_ADDR;
        end else begin
            case (state)
                S_IDLE: next_state = S_REQ;
                S_REQ: begin
                    if (rom_ack) begin
                        load_instr = 1'b1;
                        next_state = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc_d       = next_pc;
                        next_state = S_REQ;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= S_IDLE;
            pc    <= RESET_ADDR;
            instr <= '0;
        end else begin
            state <= next_state;
            pc    <= pc_d;
            if (load_instr) instr <= rom_data;
        end
    end

    // Outputs decode straight from registers; an async reset clears them at once.
    assign rom_req     = (state == S_REQ);
    assign instr_valid = (state == S_EXEC);
    assign rom_addr    = pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: stimulus pushes the expected {pc, instr} of each
// fetch; a monitor pops and compares whenever instr_valid rises.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        soft_rst;
    logic [15:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        is_c;
    logic [2:0]  jmp;
    logic        zr;
    logic        ng;
    logic [15:0] a_in;
    logic [15:0] pc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ack_delay = 0;
    logic [15:0] exp_pc;
    logic [31:0] exp_q[$];

    pc_fetch #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .soft_rst    (soft_rst),
        .rom_addr    (rom_addr),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .is_c        (is_c),
        .jmp         (jmp),
        .zr          (zr),
        .ng          (ng),
        .a_in        (a_in),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    function automatic logic model_taken(input logic c, input logic [2:0] j,
                                         input logic z, input logic n);
        if (!c)                 return 1'b0;
        if (j[2] && n)          return 1'b1;
        if (j[1] && z)          return 1'b1;
        if (j[0] && !n && !z)   return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ROM model: acks after ack_delay wait cycles of a held request.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        rom_ack  = 1'b0;
        rom_data = 16'h0;
        forever begin
            @(negedge clk);
            rom_ack = 1'b0;
            if (rom_req === 1'b1) begin
                if (wait_cnt >= ack_delay) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_word(rom_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: each new presented instruction is compared against the scoreboard.
    initial begin
        logic prev_v;
        logic [31:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1 && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fetch", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("fetch_pc", {16'h0, pc}, {16'h0, e[31:16]});
                    check("fetch_instr", {16'h0, instr}, {16'h0, e[15:0]});
                end
            end
            prev_v = (instr_valid === 1'b1);
        end
    end

    task automatic wait_exec();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("exec_timeout", 32'd0, 32'd1);
    endtask

    // Release one EXEC cycle with the given flags; returns on the first REQ negedge.
    task automatic exec_step(input logic c, input logic [2:0] j, input logic z,
                             input logic n, input logic [15:0] a, input bit push);
        wait_exec();
        is_c = c; jmp = j; zr = z; ng = n; a_in = a;
        exp_pc = model_taken(c, j, z, n) ? a : exp_pc + 16'd1;
        if (push) exp_q.push_back({exp_pc, rom_word(exp_pc)});
        stall = 1'b0;
        @(negedge clk);
        stall = 1'b1;
    endtask

    initial begin
        int          cnt;
        logic [15:0] held_instr;
        bit          rand_ok;
        int          fails_before;

        reset = 1'b1; soft_rst = 1'b0; stall = 1'b1;
        is_c = 1'b0; jmp = 3'b000; zr = 1'b0; ng = 1'b0; a_in = 16'h0;
        exp_pc = 16'h0;
        exp_q.push_back({16'h0000, rom_word(16'h0000)});
        repeat (3) @(negedge clk);
        check("rst_rom_req", {31'h0, rom_req}, 32'd0);
        check("rst_instr_valid", {31'h0, instr_valid}, 32'd0);
        check("rst_pc", {16'h0, pc}, 32'd0);
        check("rst_instr", {16'h0, instr}, 32'd0);
        reset = 1'b0;

        // 1: sequential fetch 0,1,2,3, one fetch per two cycles
        for (int k = 1; k <= 3; k++) begin
            exec_step(1'b0, 3'b000, 1'b0, 1'b0, 16'h0, 1'b1);
            check("seq_req", {31'h0, rom_req}, 32'd1);
            check("seq_addr", {16'h0, rom_addr}, k);
            @(negedge clk);
            check("seq_two_cycle", {31'h0, instr_valid}, 32'd1);
        end

        // 2: conditional jump on zero at pc=5
        repeat (2) exec_step(1'b0, 3'b000, 1'b0, 1'b0, 16'h0, 1'b1);
        exec_step(1'b1, 3'b010, 1'b1, 1'b0, 16'h0040, 1'b1);
        check("jeq_taken_addr", {16'h0, rom_addr}, 32'h0040);
        exec_step(1'b1, 3'b111, 1'b0, 1'b0, 16'h0005, 1'b1);
        exec_step(1'b1, 3'b010, 1'b0, 1'b0, 16'h0040, 1'b1);
        check("jeq_not_taken_addr", {16'h0, rom_addr}, 32'h0006);
        exec_step(1'b1, 3'b100, 1'b0, 1'b1, 16'h0100, 1'b1);
        exec_step(1'b1, 3'b001, 1'b0, 1'b1, 16'h0200, 1'b1);
        exec_step(1'b1, 3'b001, 1'b0, 1'b0, 16'h0300, 1'b1);
        exec_step(1'b1, 3'b000, 1'b1, 1'b0, 16'h0400, 1'b1);

        // 3: wrap and A-instruction with all jump bits set
        exec_step(1'b1, 3'b111, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        exec_step(1'b0, 3'b000, 1'b0, 1'b0, 16'h1234, 1'b1);
        check("wrap_addr", {16'h0, rom_addr}, 32'h0000);
        exec_step(1'b0, 3'b111, 1'b1, 1'b0, 16'h1234, 1'b1);
        check("a_instr_no_jump", {16'h0, rom_addr}, 32'h0001);

        // 4: ROM wait states, then stall in EXEC
        ack_delay = 3;
        exec_step(1'b0, 3'b000, 1'b0, 1'b0, 16'h0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) break;
            if (rom_req === 1'b1) begin
                cnt++;
                check("wait_addr_stable", {16'h0, rom_addr}, {16'h0, exp_pc});
            end
            @(negedge clk);
        end
        check("wait_req_cycles", cnt, 32'd4);
        ack_delay = 0;
        is_c = 1'b1; jmp = 3'b111; zr = 1'b1; a_in = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            check("stall_no_req", {31'h0, rom_req}, 32'd0);
            check("stall_valid", {31'h0, instr_valid}, 32'd1);
            check("stall_pc", {16'h0, pc}, {16'h0, exp_pc});
            check("stall_instr", {16'h0, instr}, {16'h0, rom_word(exp_pc)});
            @(negedge clk);
        end

        // 5: soft_rst in REQ with a same-cycle ack, then async reset in EXEC
        held_instr = rom_word(exp_pc);
        exec_step(1'b0, 3'b000, 1'b0, 1'b0, 16'h0, 1'b0);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        exp_pc = 16'h0;
        exp_q.push_back({16'h0000, rom_word(16'h0000)});
        check("srst_idle_req", {31'h0, rom_req}, 32'd0);
        check("srst_idle_valid", {31'h0, instr_valid}, 32'd0);
        check("srst_pc", {16'h0, pc}, 32'd0);
        check("srst_instr_kept", {16'h0, instr}, {16'h0, held_instr});
        @(negedge clk);
        check("srst_then_req", {31'h0, rom_req}, 32'd1);
        check("srst_req_addr", {16'h0, rom_addr}, 32'd0);

        exec_step(1'b1, 3'b111, 1'b0, 1'b0, 16'h0777, 1'b1);
        wait_exec();
        #2 reset = 1'b1;
        #1;
        check("arst_req", {31'h0, rom_req}, 32'd0);
        check("arst_valid", {31'h0, instr_valid}, 32'd0);
        check("arst_pc", {16'h0, pc}, 32'd0);
        check("arst_instr", {16'h0, instr}, 32'd0);
        @(negedge clk);
        exp_pc = 16'h0;
        exp_q.push_back({16'h0000, rom_word(16'h0000)});
        reset = 1'b0;

        // 6: random jump conditions against the reference model
        fails_before = n_checks - n_pass;
        for (int i = 0; i < 10000; i++) begin
            logic c, z, n;
            logic [2:0] j;
            c = 1'($urandom);
            j = 3'($urandom);
            z = 1'($urandom);
            n = z ? 1'b0 : 1'($urandom);
            exec_step(c, j, z, n, 16'($urandom), 1'b1);
        end
        wait_exec();
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        rand_ok = ((n_checks - n_pass) == fails_before);
        if (rand_ok) $display("random jump sequence passed");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
